// File: rtl/ra_bist_march_pkg.sv
// Shared constants and element helpers for the register-array March C- BIST engine.
package ra_bist_march_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [2:0] ELEM_M0 = 3'd0;
  localparam logic [2:0] ELEM_M1 = 3'd1;
  localparam logic [2:0] ELEM_M2 = 3'd2;
  localparam logic [2:0] ELEM_M3 = 3'd3;
  localparam logic [2:0] ELEM_M4 = 3'd4;
  localparam logic [2:0] ELEM_M5 = 3'd5;

  localparam logic [1:0] PAT_ZERO = 2'd0;
  localparam logic [1:0] PAT_55   = 2'd1;
  localparam logic [1:0] PAT_ADR  = 2'd2;
  localparam logic [1:0] PAT_RSVD = 2'd3;

  localparam int STAT_DONE     = 31;
  localparam int STAT_FAIL     = 30;
  localparam int STAT_ACTIVE   = 29;
  localparam int STAT_ELEM_LSB = 13;
  localparam int STAT_PORT     = 12;
  localparam int STAT_ADR_LSB  = 4;

  function automatic logic elem_is_down(input logic [2:0] elem);
    return (elem == ELEM_M3) || (elem == ELEM_M4);
  endfunction

  // M1..M4 do a read then a write at each address; M0 and M5 do one op.
  function automatic logic elem_two_ops(input logic [2:0] elem);
    return (elem != ELEM_M0) && (elem != ELEM_M5);
  endfunction

  function automatic logic elem_rd_inv(input logic [2:0] elem);
    return (elem == ELEM_M2) || (elem == ELEM_M4);
  endfunction

  function automatic logic elem_wr_inv(input logic [2:0] elem);
    return (elem == ELEM_M1) || (elem == ELEM_M3);
  endfunction

endpackage

// File: rtl/ra_bist_march_cmp.sv
// Read-latency delay pipe for expected data plus dual-port compare with first-fail capture.
module ra_bist_cmp
  import ra_bist_march_pkg::*;
#(
  parameter int ADR_W  = 6,
  parameter int DAT_W  = 72,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             push_vld_i,
  input  logic [DAT_W-1:0] push_exp_i,
  input  logic [2:0]       push_elem_i,
  input  logic [ADR_W-1:0] push_adr_i,
  input  logic [DAT_W-1:0] rd0_dat_i,
  input  logic [DAT_W-1:0] rd1_dat_i,
  output logic             fail_o,
  output logic [2:0]       fail_elem_o,
  output logic             fail_port_o,
  output logic [ADR_W-1:0] fail_adr_o
);

  localparam int TAIL = RD_LAT - 1;

  logic             vld_q  [RD_LAT];
  logic [DAT_W-1:0] exp_q  [RD_LAT];
  logic [2:0]       elem_q [RD_LAT];
  logic [ADR_W-1:0] adr_q  [RD_LAT];

  logic             fail_q, fail_d;
  logic [2:0]       fail_elem_q, fail_elem_d;
  logic             fail_port_q, fail_port_d;
  logic [ADR_W-1:0] fail_adr_q, fail_adr_d;
  logic             mis0, mis1;

  // Clearing the valid bits is what discards in-flight compares on abort/restart.
  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      for (int i = 0; i < RD_LAT; i++) vld_q[i] <= 1'b0;
    end else begin
      vld_q[0] <= push_vld_i;
      for (int i = 1; i < RD_LAT; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    exp_q[0]  <= push_exp_i;
    elem_q[0] <= push_elem_i;
    adr_q[0]  <= push_adr_i;
    for (int i = 1; i < RD_LAT; i++) begin
      exp_q[i]  <= exp_q[i-1];
      elem_q[i] <= elem_q[i-1];
      adr_q[i]  <= adr_q[i-1];
    end
  end

  always_comb begin
    mis0        = vld_q[TAIL] && (rd0_dat_i != exp_q[TAIL]);
    mis1        = vld_q[TAIL] && (rd1_dat_i != exp_q[TAIL]);
    fail_d      = fail_q;
    fail_elem_d = fail_elem_q;
    fail_port_d = fail_port_q;
    fail_adr_d  = fail_adr_q;
    if (!fail_q && (mis0 || mis1)) begin
      fail_d      = 1'b1;
      fail_elem_d = elem_q[TAIL];
      fail_port_d = !mis0;
      fail_adr_d  = adr_q[TAIL];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      fail_q      <= 1'b0;
      fail_elem_q <= '0;
      fail_port_q <= 1'b0;
      fail_adr_q  <= '0;
    end else begin
      fail_q      <= fail_d;
      fail_elem_q <= fail_elem_d;
      fail_port_q <= fail_port_d;
      fail_adr_q  <= fail_adr_d;
    end
  end

  assign fail_o      = fail_q;
  assign fail_elem_o = fail_elem_q;
  assign fail_port_o = fail_port_q;
  assign fail_adr_o  = fail_adr_q;

endmodule

// File: rtl/ra_bist_march.sv
// March C- BIST engine for the 64x72 two-read/one-write register array: FSM, op sequencer, data generator.
module ra_bist_march
  import ra_bist_march_pkg::*;
#(
  parameter int ADR_W  = 6,
  parameter int DAT_W  = 72,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       pattern,
  input  logic [DAT_W-1:0] rd0_dat,
  input  logic [DAT_W-1:0] rd1_dat,
  output logic             bist_rd0_enb,
  output logic [ADR_W-1:0] bist_rd0_adr,
  output logic             bist_rd1_enb,
  output logic [ADR_W-1:0] bist_rd1_adr,
  output logic             bist_wr0_enb,
  output logic [ADR_W-1:0] bist_wr0_adr,
  output logic [DAT_W-1:0] bist_wr0_dat,
  output logic             active,
  output logic [31:0]      status,
  output logic [1:0]       dbg_state
);

  localparam logic [ADR_W-1:0] ADR_MAX = '1;

  logic [1:0]       state_q, state_d;
  logic [2:0]       elem_q, elem_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic             phase_q, phase_d;
  logic [1:0]       pat_q, pat_d;
  logic [1:0]       drain_q, drain_d;

  logic             run, two_op, is_rd, is_wr, adr_end, op_last, clr;
  logic [DAT_W-1:0] bg, exp_dat, wr_dat;
  logic             fail;
  logic [2:0]       fail_elem;
  logic             fail_port;
  logic [ADR_W-1:0] fail_adr;

  // Reserved pattern code falls through to the all-zero background.
  function automatic logic [DAT_W-1:0] background(input logic [1:0] pat, input logic [ADR_W-1:0] adr);
    case (pat)
      PAT_55:  return {(DAT_W/2){2'b01}};
      PAT_ADR: return {(DAT_W/ADR_W){adr}};
      default: return '0;
    endcase
  endfunction

  always_comb begin
    run     = (state_q == ST_RUN);
    two_op  = elem_two_ops(elem_q);
    is_rd   = run && ((elem_q == ELEM_M5) || (two_op && !phase_q));
    is_wr   = run && ((elem_q == ELEM_M0) || (two_op && phase_q));
    adr_end = elem_is_down(elem_q) ? (adr_q == '0) : (adr_q == ADR_MAX);
    op_last = !two_op || phase_q;
    bg      = background(pat_q, adr_q);
    exp_dat = elem_rd_inv(elem_q) ? ~bg : bg;
    wr_dat  = elem_wr_inv(elem_q) ? ~bg : bg;
  end

  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    adr_d   = adr_q;
    phase_d = phase_q;
    pat_d   = pat_q;
    drain_d = drain_q;
    clr     = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      elem_d  = ELEM_M0;
      adr_d   = '0;
      phase_d = 1'b0;
      drain_d = '0;
      clr     = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d = ST_RUN;
            elem_d  = ELEM_M0;
            adr_d   = '0;
            phase_d = 1'b0;
            pat_d   = pattern;
            drain_d = '0;
            clr     = 1'b1;
          end
        end
        ST_RUN: begin
          if (!op_last) begin
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (!adr_end) begin
              adr_d = elem_is_down(elem_q) ? adr_q - 1'b1 : adr_q + 1'b1;
            end else if (elem_q == ELEM_M5) begin
              state_d = ST_DRAIN;
              adr_d   = '0;
            end else begin
              // The address only wraps here, reloading at the start of the next element.
              elem_d = elem_q + 3'd1;
              adr_d  = elem_is_down(elem_q + 3'd1) ? ADR_MAX : '0;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_q == 2'(RD_LAT - 1)) begin
            state_d = ST_DONE;
            drain_d = '0;
          end else begin
            drain_d = drain_q + 2'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      elem_q  <= ELEM_M0;
      adr_q   <= '0;
      phase_q <= 1'b0;
      pat_q   <= PAT_ZERO;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      adr_q   <= adr_d;
      phase_q <= phase_d;
      pat_q   <= pat_d;
      drain_q <= drain_d;
    end
  end

  ra_bist_cmp #(
    .ADR_W  (ADR_W),
    .DAT_W  (DAT_W),
    .RD_LAT (RD_LAT)
  ) u_cmp (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (clr),
    .push_vld_i  (is_rd),
    .push_exp_i  (exp_dat),
    .push_elem_i (elem_q),
    .push_adr_i  (adr_q),
    .rd0_dat_i   (rd0_dat),
    .rd1_dat_i   (rd1_dat),
    .fail_o      (fail),
    .fail_elem_o (fail_elem),
    .fail_port_o (fail_port),
    .fail_adr_o  (fail_adr)
  );

  always_comb begin
    bist_rd0_enb = is_rd;
    bist_rd1_enb = is_rd;
    bist_rd0_adr = is_rd ? adr_q : '0;
    bist_rd1_adr = is_rd ? adr_q : '0;
    bist_wr0_enb = is_wr;
    bist_wr0_adr = is_wr ? adr_q : '0;
    bist_wr0_dat = is_wr ? wr_dat : '0;
    active       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    dbg_state    = state_q;
    status                          = '0;
    status[STAT_DONE]               = (state_q == ST_DONE);
    status[STAT_FAIL]               = fail;
    status[STAT_ACTIVE]             = active;
    status[STAT_ELEM_LSB +: 3]      = fail_elem;
    status[STAT_PORT]               = fail_port;
    status[STAT_ADR_LSB +: 6]       = 6'(fail_adr);
  end

endmodule

// File: tb/tb_ra_bist_march.sv
// Directed bench for ra_bist_march: two engines (read latency 1 and 3), each against its own array model.
module tb_ra_bist_march;

  localparam int AW      = 6;
  localparam int DW      = 72;
  localparam int MAX_CYC = 700;
  localparam logic [DW-1:0] SA_MASK  = 72'd1 << 5;
  localparam logic [DW-1:0] RD1_MASK = 72'd1 << 70;

  logic clk = 1'b0;
  logic reset, start, abort;
  logic [1:0] pattern;

  logic [DW-1:0] rd0_dat [2];
  logic [DW-1:0] rd1_dat [2];
  logic [DW-1:0] wr_dat  [2];
  logic          rd0_enb [2];
  logic          rd1_enb [2];
  logic          wr_enb  [2];
  logic          active  [2];
  logic [AW-1:0] rd0_adr [2];
  logic [AW-1:0] rd1_adr [2];
  logic [AW-1:0] wr_adr  [2];
  logic [31:0]   status  [2];
  logic [1:0]    dbg_st  [2];

  always #5 clk = ~clk;

  ra_bist_march #(.ADR_W(AW), .DAT_W(DW), .RD_LAT(1)) u_dut_l1 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .pattern(pattern),
    .rd0_dat(rd0_dat[0]), .rd1_dat(rd1_dat[0]),
    .bist_rd0_enb(rd0_enb[0]), .bist_rd0_adr(rd0_adr[0]),
    .bist_rd1_enb(rd1_enb[0]), .bist_rd1_adr(rd1_adr[0]),
    .bist_wr0_enb(wr_enb[0]), .bist_wr0_adr(wr_adr[0]), .bist_wr0_dat(wr_dat[0]),
    .active(active[0]), .status(status[0]), .dbg_state(dbg_st[0])
  );

  ra_bist_march #(.ADR_W(AW), .DAT_W(DW), .RD_LAT(3)) u_dut_l3 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .pattern(pattern),
    .rd0_dat(rd0_dat[1]), .rd1_dat(rd1_dat[1]),
    .bist_rd0_enb(rd0_enb[1]), .bist_rd0_adr(rd0_adr[1]),
    .bist_rd1_enb(rd1_enb[1]), .bist_rd1_adr(rd1_adr[1]),
    .bist_wr0_enb(wr_enb[1]), .bist_wr0_adr(wr_adr[1]), .bist_wr0_dat(wr_dat[1]),
    .active(active[1]), .status(status[1]), .dbg_state(dbg_st[1])
  );

  // Array model: write lands at the edge, read data appears RD_LAT cycles after the read op.
  logic [DW-1:0] mem [2][64];
  logic [DW-1:0] p0  [2][3];
  logic [DW-1:0] p1  [2][3];
  bit fault_sa, fault_rd1;
  int wr_cnt [2];
  int rd_cnt [2];
  int ovl_cnt[2];

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (wr_enb[g])
        mem[g][wr_adr[g]] <= (fault_sa && wr_adr[g] == 6'h2A) ? (wr_dat[g] & ~SA_MASK) : wr_dat[g];
      p0[g][0] <= mem[g][rd0_adr[g]];
      p1[g][0] <= (fault_rd1 && rd1_adr[g] == 6'h3F) ? (mem[g][rd1_adr[g]] ^ RD1_MASK)
                                                     : mem[g][rd1_adr[g]];
      for (int i = 1; i < 3; i++) begin
        p0[g][i] <= p0[g][i-1];
        p1[g][i] <= p1[g][i-1];
      end
      if (wr_enb[g])  wr_cnt[g] <= wr_cnt[g] + 1;
      if (rd0_enb[g]) rd_cnt[g] <= rd_cnt[g] + 1;
      if ((rd0_enb[g] && wr_enb[g]) || (rd0_enb[g] != rd1_enb[g]) || (rd0_adr[g] != rd1_adr[g]))
        ovl_cnt[g] <= ovl_cnt[g] + 1;
    end
  end

  assign rd0_dat[0] = p0[0][0];
  assign rd1_dat[0] = p1[0][0];
  assign rd0_dat[1] = p0[1][2];
  assign rd1_dat[1] = p1[1][2];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int lat(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  // Per-run observations, captured at the falling edge of the named cycle.
  int            done_cyc [2];
  int            wr_base [2], rd_base [2], ovl_base [2];
  logic          s1_act [2], s1_wen [2];
  logic [AW-1:0] s1_wadr [2];
  logic [AW-1:0] s6_wadr [2];
  logic [DW-1:0] s6_wdat [2];
  logic          s321_ren [2];
  logic [AW-1:0] s321_radr [2];
  logic          sp_en [2], sp_act [2], sp_any [2];
  logic [31:0]   sp_stat [2];

  // Called at a falling edge: that edge is cycle 0 with start high.
  task automatic run_test(input logic [1:0] pat, input int poke_cyc, input int poke_kind);
    for (int g = 0; g < 2; g++) begin
      done_cyc[g] = -1;
      wr_base[g]  = wr_cnt[g];
      rd_base[g]  = rd_cnt[g];
      ovl_base[g] = ovl_cnt[g];
    end
    pattern = pat;
    start   = 1'b1;
    for (int c = 1; c <= MAX_CYC; c++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      reset = 1'b0;
      for (int g = 0; g < 2; g++) begin
        if (done_cyc[g] < 0 && status[g][31]) done_cyc[g] = c;
        if (c == 1) begin
          s1_act[g] = active[g]; s1_wen[g] = wr_enb[g]; s1_wadr[g] = wr_adr[g];
        end
        if (c == 6) begin
          s6_wadr[g] = wr_adr[g]; s6_wdat[g] = wr_dat[g];
        end
        if (c == 321) begin
          s321_ren[g] = rd0_enb[g]; s321_radr[g] = rd0_adr[g];
        end
        if (c == poke_cyc + 1) begin
          sp_en[g]   = rd0_enb[g] | rd1_enb[g] | wr_enb[g];
          sp_act[g]  = active[g];
          sp_stat[g] = status[g];
          sp_any[g]  = sp_en[g] | active[g] | (|rd0_adr[g]) | (|rd1_adr[g]) | (|wr_adr[g])
                     | (|wr_dat[g]) | (|status[g]);
        end
      end
      if (c == poke_cyc) begin
        case (poke_kind)
          1: start = 1'b1;
          2: begin abort = 1'b1; start = 1'b1; end
          3: reset = 1'b1;
          default: ;
        endcase
      end
      if (done_cyc[0] >= 0 && done_cyc[1] >= 0) break;
    end
  endtask

  task automatic chk_clean(input string tag);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("%s_l%0d_done_cyc", tag, lat(g)), done_cyc[g], 641 + lat(g));
      check($sformatf("%s_l%0d_status", tag, lat(g)), status[g], 32'h8000_0000);
      check($sformatf("%s_l%0d_writes", tag, lat(g)), wr_cnt[g] - wr_base[g], 320);
      check($sformatf("%s_l%0d_reads", tag, lat(g)), rd_cnt[g] - rd_base[g], 320);
      check($sformatf("%s_l%0d_op_rules", tag, lat(g)), ovl_cnt[g] - ovl_base[g], 0);
    end
  endtask

  task automatic chk_fail(input string tag, input logic [2:0] elem, input logic port,
                          input logic [5:0] adr);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("%s_l%0d_done_cyc", tag, lat(g)), done_cyc[g], 641 + lat(g));
      check($sformatf("%s_l%0d_flags", tag, lat(g)), status[g][31:29], 3'b110);
      check($sformatf("%s_l%0d_elem", tag, lat(g)), status[g][15:13], elem);
      check($sformatf("%s_l%0d_port", tag, lat(g)), status[g][12], port);
      check($sformatf("%s_l%0d_adr", tag, lat(g)), status[g][9:4], adr);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; pattern = 2'd0;
    fault_sa = 1'b0; fault_rd1 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("reset_l%0d_status", lat(g)), status[g], 32'h0);
      check($sformatf("reset_l%0d_enables", lat(g)), {rd0_enb[g], rd1_enb[g], wr_enb[g], active[g]}, 4'b0);
      check($sformatf("reset_l%0d_state", lat(g)), dbg_st[g], 2'd0);
    end

    run_test(2'd0, -10, 0);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("c1_l%0d_active", lat(g)), s1_act[g], 1'b1);
      check($sformatf("c1_l%0d_wr_enb", lat(g)), s1_wen[g], 1'b1);
      check($sformatf("c1_l%0d_wr_adr", lat(g)), s1_wadr[g], 6'h00);
      check($sformatf("done_l%0d_state", lat(g)), dbg_st[g], 2'd3);
    end
    chk_clean("clean_p0");

    fault_sa = 1'b1;
    run_test(2'd0, -10, 0);
    fault_sa = 1'b0;
    chk_fail("stuck_2a", 3'd2, 1'b0, 6'h2A);

    fault_rd1 = 1'b1;
    run_test(2'd0, -10, 0);
    fault_rd1 = 1'b0;
    chk_fail("rd1_3f", 3'd1, 1'b1, 6'h3F);

    run_test(2'd2, -10, 0);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("p2_c6_l%0d_wr_adr", lat(g)), s6_wadr[g], 6'h05);
      check($sformatf("p2_c6_l%0d_wr_dat", lat(g)), s6_wdat[g], 72'h145145145145145145);
      check($sformatf("p2_m3_l%0d_rd_enb", lat(g)), s321_ren[g], 1'b1);
      check($sformatf("p2_m3_l%0d_rd_adr", lat(g)), s321_radr[g], 6'h3F);
    end
    chk_clean("clean_p2");

    run_test(2'd1, -10, 0);
    chk_clean("clean_p1");
    run_test(2'd3, -10, 0);
    chk_clean("clean_p3");

    run_test(2'd0, 100, 1);
    chk_clean("start_ignored");

    run_test(2'd0, 300, 2);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("abort_l%0d_enables", lat(g)), sp_en[g], 1'b0);
      check($sformatf("abort_l%0d_active", lat(g)), sp_act[g], 1'b0);
      check($sformatf("abort_l%0d_done", lat(g)), sp_stat[g][31], 1'b0);
      check($sformatf("abort_l%0d_never_done", lat(g)), done_cyc[g] < 0, 1'b1);
    end
    run_test(2'd0, -10, 0);
    chk_clean("after_abort");

    run_test(2'd0, 400, 3);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("reset400_l%0d_outputs", lat(g)), sp_any[g], 1'b0);
      check($sformatf("reset400_l%0d_never_done", lat(g)), done_cyc[g] < 0, 1'b1);
    end
    run_test(2'd0, -10, 0);
    chk_clean("after_reset");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
